// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, types and helpers for the 4x4 keypad scanner.
//   ROWS / COLS      : keypad geometry
//   SCAN_CNT_DEF     : default row dwell terminal count (dwell = SCAN_CNT+1 clocks)
//   DEB_FRAMES_DEF   : default number of identical frames needed to accept a map
//   KEY_W            : width of the key code (row*4+col)
package keypad_pkg;

  localparam int unsigned ROWS           = 4;
  localparam int unsigned COLS           = 4;
  localparam int unsigned MAP_W          = ROWS * COLS;
  localparam int unsigned SCAN_CNT_DEF   = 100000;
  localparam int unsigned DEB_FRAMES_DEF = 3;
  localparam int unsigned KEY_W          = 4;

  typedef logic [MAP_W-1:0] key_map_t;
  typedef logic [KEY_W-1:0] key_code_t;

  // True when exactly one key bit is set.
  function automatic logic is_single(input key_map_t m);
    return (m != '0) && ((m & (m - key_map_t'(1))) == '0);
  endfunction

  // Index of the set bit; only meaningful when is_single(m).
  function automatic key_code_t key_encode(input key_map_t m);
    key_code_t c;
    c = '0;
    for (int unsigned i = 0; i < MAP_W; i++) begin
      if (m[i]) c = key_code_t'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync: 2-flop synchronizer for asynchronous inputs.
//   i_Clk    : destination clock
//   i_Rst    : synchronous active-high reset, clears both stages
//   async_in : asynchronous input bus
//   sync_out : synchronized bus, two clocks of latency
module key_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame-level debounce.
//   i_Clk      : system clock
//   i_Rst      : synchronous active-high reset
//   i_Key_Col  : asynchronous column returns, active-high
//   o_Scan_Row : one-hot row drive, active-high
//   o_Key      : code (row*4+col) of the last accepted single-key press
//   o_fValid   : one-clock pulse on a new single-key press
//   o_Pressed  : high while the debounced map is non-zero
//   o_Key_Map  : debounced key map, bit row*4+col set when pressed
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CNT   = SCAN_CNT_DEF,
  parameter int unsigned DEB_FRAMES = DEB_FRAMES_DEF
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [COLS-1:0]  i_Key_Col,
  output logic [ROWS-1:0]  o_Scan_Row,
  output logic [KEY_W-1:0] o_Key,
  output logic             o_fValid,
  output logic             o_Pressed,
  output logic [MAP_W-1:0] o_Key_Map
);

  localparam int unsigned CNT_W = (SCAN_CNT < 1) ? 1 : $clog2(SCAN_CNT + 1);
  localparam int unsigned DEB_W = (DEB_FRAMES < 1) ? 1 : $clog2(DEB_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SCAN_CNT);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_FRAMES);

  logic [COLS-1:0]  col_sync;
  logic [CNT_W-1:0] dwell_cnt;
  logic [1:0]       row_idx;
  key_map_t         frame_acc;
  key_map_t         frame_next;
  key_map_t         prev_frame;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] deb_next;
  logic             commit_q;
  logic             dwell_end;
  logic             frame_end;

  key_sync #(.WIDTH(COLS)) u_sync (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .async_in (i_Key_Col),
    .sync_out (col_sync)
  );

  assign dwell_end = (dwell_cnt == CNT_END);
  assign frame_end = dwell_end && (row_idx == 2'd3);

  // Frame as it will look after this clock's sample; at frame end this
  // already contains row 3, so debounce compares the complete frame.
  always_comb begin
    frame_next = frame_acc;
    frame_next[row_idx*COLS +: COLS] = col_sync;
  end

  always_comb begin
    deb_next = DEB_W'(1);
    if (frame_next == prev_frame) begin
      deb_next = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      dwell_cnt  <= '0;
      row_idx    <= '0;
      o_Scan_Row <= 4'b0001;
      frame_acc  <= '0;
      prev_frame <= '0;
      deb_cnt    <= '0;
      commit_q   <= 1'b0;
      o_Key_Map  <= '0;
      o_Key      <= '0;
      o_fValid   <= 1'b0;
      o_Pressed  <= 1'b0;
    end else begin
      o_fValid <= 1'b0;
      commit_q <= 1'b0;

      if (dwell_end) begin
        dwell_cnt  <= '0;
        row_idx    <= row_idx + 1'b1;
        o_Scan_Row <= {o_Scan_Row[ROWS-2:0], o_Scan_Row[ROWS-1]};
        frame_acc  <= frame_next;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end

      if (frame_end) begin
        deb_cnt  <= deb_next;
        commit_q <= (deb_next == DEB_MAX);
        if (frame_next != prev_frame) prev_frame <= frame_next;
      end

      // Map update lands one clock after the accepting frame-end sample.
      if (commit_q && (prev_frame != o_Key_Map)) begin
        o_Key_Map <= prev_frame;
        o_Pressed <= |prev_frame;
        if ((o_Key_Map == '0) && is_single(prev_frame)) begin
          o_fValid <= 1'b1;
          o_Key    <= key_encode(prev_frame);
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SCAN_CNT=7, DEB_FRAMES=3
// (32-clock frames). The keypad is modelled as i_Key_Col = OR of the pressed
// columns in the currently driven row.
module tb_keypad_scan;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic [3:0]  i_Key_Col;
  logic [3:0]  o_Scan_Row;
  logic [3:0]  o_Key;
  logic        o_fValid;
  logic        o_Pressed;
  logic [15:0] o_Key_Map;

  logic [15:0] keys = '0;
  int          cyc;
  int          vcount = 0;
  int          vcyc = -1;
  logic [3:0]  vkey = '0;
  int          checks = 0;
  int          failures = 0;

  keypad_scan #(.SCAN_CNT(7), .DEB_FRAMES(3)) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Key_Col  (i_Key_Col),
    .o_Scan_Row (o_Scan_Row),
    .o_Key      (o_Key),
    .o_fValid   (o_fValid),
    .o_Pressed  (o_Pressed),
    .o_Key_Map  (o_Key_Map)
  );

  always #5 i_Clk = ~i_Clk;

  always_comb begin
    i_Key_Col = '0;
    for (int r = 0; r < 4; r++) begin
      if (o_Scan_Row[r]) i_Key_Col = i_Key_Col | keys[r*4 +: 4];
    end
  end

  // Clocks since the last reset release.
  always @(posedge i_Clk) begin
    if (i_Rst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Every clock with o_fValid high is counted, so a stretched pulse shows up.
  always @(negedge i_Clk) begin
    if (o_fValid) begin
      vcount <= vcount + 1;
      vcyc   <= cyc;
      vkey   <= o_Key;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic reset_dut(input int n, input string tag);
    @(negedge i_Clk);
    i_Rst = 1'b1;
    repeat (n) @(negedge i_Clk);
    check({tag, "_row"},     32'(o_Scan_Row), 32'h1);
    check({tag, "_map"},     32'(o_Key_Map),  32'h0);
    check({tag, "_key"},     32'(o_Key),      32'h0);
    check({tag, "_valid"},   32'(o_fValid),   32'h0);
    check({tag, "_pressed"}, 32'(o_Pressed),  32'h0);
    i_Rst = 1'b0;
  endtask

  initial begin
    // Reset state and row dwell timing.
    reset_dut(3, "rst");
    check("row0_c0", 32'(o_Scan_Row), 32'h1);
    for (int i = 1; i < 8; i++) begin
      run(1);
      check("row0_dwell", 32'(o_Scan_Row), 32'h1);
    end
    run(1);
    check("row1_start", 32'(o_Scan_Row), 32'h2);
    check("idle_map", 32'(o_Key_Map), 32'h0);

    // Steady key 9: frames end at clocks 32/64/96, map and pulse at 97.
    keys = 16'h0200;
    reset_dut(3, "rst2");
    run(96);
    check("k9_precommit_map", 32'(o_Key_Map), 32'h0);
    run(4);
    check("k9_vcount", 32'(vcount), 32'd1);
    check("k9_vcyc",   32'(vcyc),   32'd97);
    check("k9_map",    32'(o_Key_Map), 32'h0200);
    check("k9_key",    32'(o_Key),  32'd9);
    check("k9_pressed",32'(o_Pressed), 32'h1);

    // Release, then key 15.
    keys = 16'h0000;
    run(128);
    check("rel_map",     32'(o_Key_Map), 32'h0);
    check("rel_pressed", 32'(o_Pressed), 32'h0);
    check("rel_key",     32'(o_Key),     32'd9);
    check("rel_vcount",  32'(vcount),    32'd1);
    keys = 16'h8000;
    run(160);
    check("k15_vcount", 32'(vcount),    32'd2);
    check("k15_vkey",   32'(vkey),      32'd15);
    check("k15_key",    32'(o_Key),     32'd15);
    check("k15_map",    32'(o_Key_Map), 32'h8000);

    // Two keys at once: map updates, no pulse, key held.
    keys = 16'h0000;
    run(128);
    keys = 16'h0021;
    run(160);
    check("k0k5_map",     32'(o_Key_Map), 32'h0021);
    check("k0k5_pressed", 32'(o_Pressed), 32'h1);
    check("k0k5_vcount",  32'(vcount),    32'd2);
    check("k0k5_key",     32'(o_Key),     32'd15);

    // Key 9, then slide to key 0 without release.
    keys = 16'h0000;
    run(128);
    keys = 16'h0200;
    run(160);
    check("k9b_vcount", 32'(vcount), 32'd3);
    check("k9b_key",    32'(o_Key),  32'd9);
    keys = 16'h0001;
    run(160);
    check("slide_map",    32'(o_Key_Map), 32'h0001);
    check("slide_vcount", 32'(vcount),    32'd3);
    check("slide_key",    32'(o_Key),     32'd9);

    // Two-frame glitch never reaches the map.
    keys = 16'h0000;
    run(128);
    check("pre_glitch_map", 32'(o_Key_Map), 32'h0);
    keys = 16'h0200;
    run(64);
    keys = 16'h0000;
    run(160);
    check("glitch_map",     32'(o_Key_Map), 32'h0);
    check("glitch_pressed", 32'(o_Pressed), 32'h0);
    check("glitch_vcount",  32'(vcount),    32'd3);

    // Reset mid-frame while key 9 is two frames into its debounce.
    keys = 16'h0200;
    reset_dut(3, "rst3");
    run(70);
    check("mid_map", 32'(o_Key_Map), 32'h0);
    reset_dut(2, "rst_mid");
    run(96);
    check("post_rst_precommit", 32'(o_Key_Map), 32'h0);
    run(4);
    check("post_rst_vcount", 32'(vcount), 32'd4);
    check("post_rst_vcyc",   32'(vcyc),   32'd97);
    check("post_rst_key",    32'(o_Key),  32'd9);
    check("post_rst_map",    32'(o_Key_Map), 32'h0200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter SCAN_CNT, default 100000, giving the row dwell as SCAN_CNT+1 clocks (2 ms at 50 MHz).
REQ-002 The block SHALL have parameter DEB_FRAMES, default 3, giving the number of consecutive identical frames required to accept a key map.
REQ-003 The block SHALL have port i_Clk, input, 1 bit: the single clock (50 MHz).
REQ-004 The block SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_Key_Col, input, 4 bits: asynchronous keypad column returns, active-high.
REQ-006 The block SHALL have port o_Scan_Row, output, 4 bits: one-hot row drive, active-high.
REQ-007 The block SHALL have port o_Key, output, 4 bits: code of the last accepted key, equal to row*4+col.
REQ-008 The block SHALL have port o_fValid, output, 1 bit: one-clock pulse for a new single-key press.
REQ-009 The block SHALL have port o_Pressed, output, 1 bit: level that is high while the debounced map is non-zero.
REQ-010 The block SHALL have port o_Key_Map, output, 16 bits: debounced key map, where bit row*4+col is high when that key is pressed.

Function
REQ-011 i_Key_Col SHALL pass through a 2-flop synchronizer before any use.
REQ-012 A dwell counter SHALL count 0..SCAN_CNT; at SCAN_CNT it SHALL wrap to 0, and o_Scan_Row SHALL rotate left (0001->0010->0100->1000->0001) on the following edge.
REQ-013 The synchronized columns SHALL be sampled only when the dwell counter equals SCAN_CNT, into frame bits [row*4 +: 4] of the currently driven row.
REQ-014 A frame SHALL be complete at the sample for row 3; frame period = 4*(SCAN_CNT+1) clocks.
REQ-015 At frame end, if the frame equals the previous frame, the debounce count SHALL increment, saturating at DEB_FRAMES; otherwise the previous frame SHALL be replaced and the count set to 1.
REQ-016 When the count reaches DEB_FRAMES and the frame differs from o_Key_Map, o_Key_Map SHALL load the frame one clock after the frame-end sample.
REQ-017 o_fValid SHALL pulse high in the same clock as the o_Key_Map update, and o_Key SHALL load the key code in that clock, only when the old map was zero and the new map has exactly one bit set.
REQ-018 A map change with multiple keys set, a change from one key to another without release, or a release SHALL update o_Key_Map and o_Pressed but SHALL NOT pulse o_fValid or change o_Key.
REQ-019 o_Key SHALL hold its value until the next valid press.
REQ-020 o_Pressed SHALL be the OR of o_Key_Map, registered with it.
REQ-021 Glitches shorter than DEB_FRAMES frames SHALL never reach o_Key_Map.
REQ-022 The scan SHALL run continuously, with no handshake stalling it.

Reset
REQ-023 When i_Rst is high at a clock edge, o_Scan_Row SHALL become 4'b0001, and the dwell counter, frame accumulator, previous frame, debounce count, synchronizer flops, o_Key_Map, o_Key, o_fValid and o_Pressed SHALL become 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; scanning SHALL restart at row 0 with count 0 on the first clock after i_Rst falls.

Structure
REQ-025 A shared package keypad_pkg SHALL hold constants ROWS=4, COLS=4, the default SCAN_CNT and DEB_FRAMES, and the key-code width.
REQ-026 The 2-flop synchronizer SHALL be a sub-module named key_sync, parameterized by width.
REQ-027 The remaining logic (counter, row rotation, accumulator, debounce, event detect) SHALL be flat in keypad_scan.

Verification (SCAN_CNT=7, DEB_FRAMES=3, frame = 32 clocks; the bench models the keypad as i_Key_Col = OR of pressed columns in the driven row)
REQ-028 Hold i_Rst for 3 clocks, then release -> o_Scan_Row=0001 for 8 clocks, then 0010; all other outputs are 0.
REQ-029 Press key row 2, col 1 steadily -> after the 3rd identical frame: o_Key_Map=16'h0200, o_Key=9, a single-cycle o_fValid, and o_Pressed=1.
REQ-030 Press key 9 for 2 frames only, then release -> no o_fValid; o_Key_Map stays 0.
REQ-031 Press keys 0 and 5 together -> o_Key_Map=16'h0021, o_Pressed=1, no o_fValid, o_Key unchanged.
REQ-032 Hold key 9, then release, then press key 15 -> o_Key_Map=0 and o_Pressed=0 after release; then o_fValid with o_Key=15.
REQ-033 Assert i_Rst mid-frame while key 9 is debouncing -> all outputs are 0, and 3 full frames are needed after reset before o_fValid.
